// File: rtl/weight_mem_arb.sv
// weight_mem_arb: round-robin share of one weight-memory read port between two line loaders
//   clk, rst_n          clock, async active-low reset
//   restart[1:0]        rewind requester line counter to its base, cancel its pending/in-flight line
//   req_mem[1:0]        one-cycle line request per requester
//   mem_ready[1:0]      one-cycle pulse: line for that requester is on mem_data0/mem_data1
//   mem_data0/1         delivered line per requester, held until its next delivery
//   rd_req, rd_addr     memory read strobe and line address
//   rd_valid, rd_data   memory response strobe and line
//   err[1:0]            sticky per-requester protocol error
module weight_mem_arb #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 12,
    parameter int BASE0  = 0,
    parameter int LINES0 = 246,
    parameter int BASE1  = 256,
    parameter int LINES1 = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            restart,
    input  logic [1:0]            req_mem,
    output logic [1:0]            mem_ready,
    output logic [WORDS*16-1:0]   mem_data0,
    output logic [WORDS*16-1:0]   mem_data1,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_valid,
    input  logic [WORDS*16-1:0]   rd_data,
    output logic [1:0]            err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
    localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] E0 = ADDR_W'(BASE0 + LINES0 - 1);
    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BASE1);
    localparam logic [ADDR_W-1:0] E1 = ADDR_W'(BASE1 + LINES1 - 1);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt0, cnt1;
    logic [1:0]        pend, gmask, busy, iss, req_bad, req_ok;
    logic              ptr, g, drop, cancel, load;
    always_comb begin
        gmask   = g ? 2'b10 : 2'b01;
        busy    = (state != IDLE) ? gmask : 2'b00;
        iss     = (state == ISSUE) ? gmask : 2'b00;
        // a restart in the same cycle wipes the old request first, so the new one is legal
        req_bad = req_mem & (pend | busy) & ~restart;
        req_ok  = req_mem & ~req_bad;
        // the in-flight line is discarded once its requester has restarted
        cancel  = drop || (|(restart & gmask));
        load    = (state == WAIT) && rd_valid && !cancel;
        rd_req  = (state == ISSUE);
        rd_addr = rd_req ? (g ? cnt1 : cnt0) : '0;
        state_nx = state;
        case (state)
            IDLE:    state_nx = (|pend) ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = rd_valid ? DELIVER : WAIT;
            DELIVER: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt0      <= B0;
            cnt1      <= B1;
            pend      <= '0;
            ptr       <= 1'b0;
            g         <= 1'b0;
            drop      <= 1'b0;
            err       <= '0;
            mem_ready <= '0;
            mem_data0 <= '0;
            mem_data1 <= '0;
        end else begin
            state <= state_nx;
            pend  <= (pend & ~iss & ~restart) | req_ok;
            err   <= err | req_bad;
            cnt0  <= restart[0] ? B0 : iss[0] ? ((cnt0 == E0) ? B0 : cnt0 + 1'b1) : cnt0;
            cnt1  <= restart[1] ? B1 : iss[1] ? ((cnt1 == E1) ? B1 : cnt1 + 1'b1) : cnt1;
            // pend[ptr] wins ties, otherwise the other requester must be the pending one
            if (state == IDLE && |pend)
                g <= pend[ptr] ? ptr : ~ptr;
            if (state == ISSUE)
                ptr <= ~g;
            drop <= (state == DELIVER) ? 1'b0 : (drop || (|(restart & busy)));
            if (load && !g)
                mem_data0 <= rd_data;
            if (load && g)
                mem_data1 <= rd_data;
            // ready follows the data register by one cycle
            mem_ready <= (state == DELIVER && !cancel) ? gmask : 2'b00;
        end
    end
endmodule

// File: tb/tb_weight_mem_arb.sv
// tb_weight_mem_arb: scoreboard bench for weight_mem_arb with a latency-programmable memory model
module tb_weight_mem_arb;
    localparam int W = 32 * 16;
    typedef struct {
        logic [11:0] addr;
        bit          deliver;
    } iss_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   restart = '0;
    logic [1:0]   req_mem = '0;
    logic [1:0]   mem_ready;
    logic [W-1:0] mem_data0, mem_data1;
    logic         rd_req;
    logic [11:0]  rd_addr;
    logic         rd_valid = 1'b0;
    logic [W-1:0] rd_data = '0;
    logic [1:0]   err;
    int           passed = 0;
    int           total = 0;
    int           reads = 0;
    int           lat = 3;
    bit           rnd = 1'b0;
    iss_t         iq[$];
    logic [W-1:0] dq0[$];
    logic [W-1:0] dq1[$];
    iss_t         e;
    logic [W-1:0] x;
    weight_mem_arb dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .req_mem(req_mem),
        .mem_ready(mem_ready), .mem_data0(mem_data0), .mem_data1(mem_data1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );
    always #5 clk = ~clk;
    function automatic logic [W-1:0] line_of(input logic [11:0] a);
        logic [W-1:0] l;
        for (int i = 0; i < 32; i++)
            l[i*16 +: 16] = 16'(a) * 16'd3 + 16'(i * 41) + 16'h1234;
        return l;
    endfunction
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req) begin
                automatic logic [11:0] a = rd_addr;
                automatic int l = rnd ? int'($urandom_range(1, 8)) : lat;
                repeat (l) @(posedge clk);
                #1 rd_valid = 1'b1;
                rd_data = line_of(a);
                @(posedge clk);
                #1 rd_valid = 1'b0;
                rd_data = '0;
            end
        end
    end
    always @(negedge clk) begin
        if (rd_req) begin
            total++;
            reads++;
            if (iq.size() == 0)
                $display("FAIL rd_req unexpected: got addr %0d, required no read", rd_addr);
            else begin
                e = iq.pop_front();
                if (rd_addr !== e.addr)
                    $display("FAIL rd_addr: got %0d, required %0d", rd_addr, e.addr);
                else
                    passed++;
                if (e.deliver && e.addr >= 12'd256)
                    dq1.push_back(line_of(e.addr));
                else if (e.deliver)
                    dq0.push_back(line_of(e.addr));
            end
        end
        if (mem_ready[0]) begin
            total++;
            if (dq0.size() == 0)
                $display("FAIL mem_ready0 unexpected: got 1, required 0");
            else begin
                x = dq0.pop_front();
                if (mem_data0 !== x)
                    $display("FAIL mem_data0: got %h, required %h", mem_data0, x);
                else
                    passed++;
            end
        end
        if (mem_ready[1]) begin
            total++;
            if (dq1.size() == 0)
                $display("FAIL mem_ready1 unexpected: got 1, required 0");
            else begin
                x = dq1.pop_front();
                if (mem_data1 !== x)
                    $display("FAIL mem_data1: got %h, required %h", mem_data1, x);
                else
                    passed++;
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
    task automatic push(input logic [11:0] a, input bit d);
        iss_t t;
        t.addr = a;
        t.deliver = d;
        iq.push_back(t);
    endtask
    task automatic pulse(input logic [1:0] r, input logic [1:0] rs);
        @(posedge clk);
        #1 req_mem = r;
        restart = rs;
        @(posedge clk);
        #1 req_mem = '0;
        restart = '0;
    endtask
    task automatic drain(output bit ok);
        int k = 0;
        while ((iq.size() != 0 || dq0.size() != 0 || dq1.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        ok = (k < 200);
    endtask
    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({rd_req, rd_addr, mem_ready, err} !== '0)
            $display("FAIL reset ctrl: got rd_req=%b rd_addr=%0d ready=%b err=%b, required 0", rd_req, rd_addr, mem_ready, err);
        else passed++;
        total++;
        if (mem_data0 !== '0 || mem_data1 !== '0)
            $display("FAIL reset data: got %h / %h, required 0", mem_data0, mem_data1);
        else passed++;
    endtask
    task automatic test_single();
        bit ok;
        do_reset();
        lat = 3;
        for (int k = 0; k < 3; k++) begin
            push(12'(k), 1'b1);
            pulse(2'b01, 2'b00);
            if (k == 0) begin
                @(negedge clk);
                total++;
                if (rd_req !== 1'b0) $display("FAIL early rd_req: got %b, required 0", rd_req);
                else passed++;
                @(negedge clk);
                total++;
                if (rd_req !== 1'b1) $display("FAIL rd_req latency: got %b, required 1", rd_req);
                else passed++;
                repeat (4) @(negedge clk);
                total++;
                if (mem_ready !== 2'b00) $display("FAIL early ready: got %b, required 00", mem_ready);
                else passed++;
                @(negedge clk);
                total++;
                if (mem_ready !== 2'b01) $display("FAIL ready latency: got %b, required 01", mem_ready);
                else passed++;
            end
            drain(ok);
            total++;
            if (!ok) $display("FAIL single drain: got timeout, required delivery");
            else passed++;
        end
        total++;
        if (err !== 2'b00) $display("FAIL single err: got %b, required 00", err);
        else passed++;
    endtask
    task automatic test_both();
        bit ok;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(12'(k), 1'b1);
            push(12'(256 + k), 1'b1);
            pulse(2'b11, 2'b00);
            drain(ok);
            total++;
            if (!ok) $display("FAIL both drain %0d: got timeout, required delivery", k);
            else passed++;
        end
    endtask
    task automatic test_wrap();
        bit ok;
        int a = 0;
        int r0;
        do_reset();
        rnd = 1'b1;
        r0 = reads;
        for (int k = 0; k < 247; k++) begin
            push(12'(a), 1'b1);
            a = (a == 245) ? 0 : a + 1;
            pulse(2'b01, 2'b00);
            drain(ok);
            if (!ok) begin
                total++;
                $display("FAIL wrap drain %0d: got timeout, required delivery", k);
            end
        end
        rnd = 1'b0;
        total++;
        if (reads - r0 !== 247) $display("FAIL wrap reads: got %0d, required 247", reads - r0);
        else passed++;
        total++;
        if (err !== 2'b00) $display("FAIL wrap err: got %b, required 00", err);
        else passed++;
    endtask
    task automatic test_protocol();
        bit ok;
        int r0;
        do_reset();
        lat = 3;
        r0 = reads;
        push(12'd256, 1'b1);
        pulse(2'b10, 2'b00);
        pulse(2'b10, 2'b00);
        drain(ok);
        repeat (6) @(posedge clk);
        total++;
        if (!ok) $display("FAIL protocol drain: got timeout, required delivery");
        else passed++;
        total++;
        if (err !== 2'b10) $display("FAIL protocol err: got %b, required 10", err);
        else passed++;
        total++;
        if (reads - r0 !== 1) $display("FAIL protocol reads: got %0d, required 1", reads - r0);
        else passed++;
    endtask
    task automatic test_restart();
        bit ok;
        int k = 0;
        logic [W-1:0] old;
        do_reset();
        lat = 5;
        old = mem_data0;
        push(12'd0, 1'b0);
        pulse(2'b01, 2'b00);
        while (iq.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        pulse(2'b00, 2'b01);
        repeat (12) @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_data0 !== old) $display("FAIL restart data: got %h, required %h", mem_data0, old);
        else passed++;
        push(12'd0, 1'b1);
        pulse(2'b01, 2'b00);
        drain(ok);
        total++;
        if (!ok) $display("FAIL restart drain: got timeout, required delivery");
        else passed++;
    endtask
    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        lat = 6;
        push(12'd256, 1'b0);
        pulse(2'b10, 2'b00);
        while (iq.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({rd_req, rd_addr, mem_ready, err} !== '0 || mem_data0 !== '0 || mem_data1 !== '0)
            $display("FAIL mid reset: got rd_req=%b ready=%b err=%b, required all outputs 0", rd_req, mem_ready, err);
        else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_data1 !== '0) $display("FAIL late rd_valid data: got %h, required 0", mem_data1);
        else passed++;
        push(12'd0, 1'b1);
        push(12'd256, 1'b1);
        pulse(2'b11, 2'b00);
        drain(ok);
        total++;
        if (!ok) $display("FAIL post-reset drain: got timeout, required delivery");
        else passed++;
    endtask
    initial begin
        test_reset();
        test_single();
        test_both();
        test_wrap();
        test_protocol();
        test_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
